// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control path: state encoding,
// default timing parameters and the datapath count limit.
package stopwatch_pkg;

  // Encoded controller state as seen on the state output.
  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // 10 ms of stable input at 100 MHz before a debounced level changes.
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  // 10 Hz count tick at 100 MHz.
  localparam int DEF_TICK_DIV        = 10_000_000;
  // Largest value of the 0..9999 display counter.
  localparam int COUNT_MAX           = 9999;

endpackage

// File: rtl/btn_debounce.sv
// One push-button input path: 2-FF synchronizer, stable-count debouncer
// and a registered rising-edge detector producing a one-cycle press.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the raw asynchronous button into the clk domain; sync_q[1] is safe to use.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], btn_in};
  end

  // Count consecutive cycles the synced value disagrees with the debounced level;
  // any agreement restarts the count, reaching the last count adopts the new value.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state plus the edge detector; press fires the cycle after level rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
      cnt_q        <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounces run/clear buttons, sequences STOP/RUN/CLEAR
// and produces the count-enable tick and the synchronous counter clear.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = DEF_TICK_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_clear,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       running,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Index 0 is the run/stop button, index 1 the clear button.
  logic [1:0] btn_raw;
  logic [1:0] btn_press;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q;
  logic          tick;

  assign btn_raw = {btn_clear, btn_run};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
        .clk   (clk),
        .reset (reset),
        .btn_in(btn_raw[gi]),
        .level (),
        .press (btn_press[gi])
      );
    end
  endgenerate

  // Count period ends on the last prescaler value while running.
  assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

  // Next state and next prescaler; clear wins over run in STOP, clear is ignored in RUN.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    case (state_q)
      ST_STOP: begin
        if (btn_press[1])      state_d = ST_CLEAR;
        else if (btn_press[0]) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (btn_press[0]) state_d = ST_STOP;
        presc_d = tick ? '0 : presc_q + 1'b1;
      end
      ST_CLEAR: begin
        state_d = ST_STOP;
        presc_d = '0;
      end
      default: state_d = ST_STOP;
    endcase
  end

  // State, prescaler and the registered running flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_STOP;
      presc_q   <= '0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign state   = state_q;
  assign running = running_q;
  assign cnt_clr = (state_q == ST_CLEAR);
  assign cnt_en  = tick;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM for the 0..9999 up-counter. It turns two raw push-buttons (run/stop toggle, clear) into clean press events and sequences the counter through STOP, RUN and CLEAR states. It produces a single-cycle count-enable tick on the system clock, which replaces the derived divided clock, plus a synchronous clear pulse. It sits between the board buttons and the counter/FND datapath, and everything runs in the one system-clock domain.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz).
TICK_DIV, 10_000_000, system clocks per count tick (10 Hz at 100 MHz); must be >= 2.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
btn_run  input  1  raw run/stop button, asynchronous, active-high.
btn_clear  input  1  raw clear button, asynchronous, active-high.
cnt_en  output  1  one-cycle pulse; the counter increments by 1 (wraps 9999->0) on this cycle.
cnt_clr  output  1  one-cycle pulse; the counter loads 0; has priority over cnt_en in the counter.
running  output  1  1 while the state is RUN (drives a status LED).
state  output  2  encoded state: STOP=2'd0, RUN=2'd1, CLEAR=2'd2; 2'd3 unused.

Behaviour:
- Reset (reset=0, async): state=STOP, prescaler=0, sync/debounce registers=0, debounce counters=0. All outputs are 0.
- Input path per button: 2-FF synchronizer, then the debouncer, then a rising-edge detector.
- Debouncer: while the synced value differs from the debounced level, the stable counter increments. Any change back to the debounced level returns the counter to 0. When the counter reaches DEBOUNCE_CYCLES-1 with the value still different, the debounced level takes the new value and the counter returns to 0.
- Press pulse: 1 cycle, in the cycle after the debounced level rises 0->1. Release produces no event.
- Latency: for a raw high held stable, the press pulse appears 2+DEBOUNCE_CYCLES+1 clocks after the first clk edge that samples the high. Bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- FSM transitions, evaluated on press pulses:
  - STOP: clear press -> CLEAR. Otherwise run press -> RUN. Otherwise stay.
  - RUN: run press -> STOP. Clear press is ignored while running.
  - CLEAR: unconditional -> STOP after 1 cycle. Presses in this cycle are dropped.
  - Simultaneous run and clear press in STOP: clear wins; the run press is dropped.
  - Unused encoding 2'd3 -> STOP.
- cnt_clr = 1 exactly during the cycle state==CLEAR.
- Prescaler (0..TICK_DIV-1):
  - Increments only while state==RUN, wrapping to 0 after TICK_DIV-1.
  - Holds its value in STOP, so a stopped stopwatch resumes mid-period.
  - Forced to 0 in CLEAR.
- cnt_en = 1 in the cycle where state==RUN and prescaler==TICK_DIV-1. It is never asserted outside RUN and never in the same cycle as cnt_clr.
- A run press in the same cycle as a tick: state goes to STOP next cycle, and the tick in that cycle is still issued.
- running = (state==RUN), registered with the state.
- Asserting reset mid-operation returns to STOP instantly. Any pending debounce progress is lost, and the counter datapath is reset by the same reset.

Decomposition:
- Package stopwatch_pkg: state encoding constants (ST_STOP, ST_RUN, ST_CLEAR), default DEBOUNCE_CYCLES, TICK_DIV, and COUNT_MAX=9999 for the datapath.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, btn_in, level, press) holds the synchronizer, debouncer and edge detector. It is instantiated twice.
- FSM and prescaler stay in stopwatch_ctrl.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4 and TICK_DIV=5.
1. Reset held 0 then released -> state=0, cnt_en=0, cnt_clr=0, running=0. No cnt_en over 50 clocks.
2. btn_run high, held stable -> press at clock 7 after first sample, state=1 next cycle. cnt_en pulses every 5 clocks; the first comes 5 clocks after entering RUN.
3. btn_run bounces high 3 clocks, low 1, repeated 5 times -> no press and state stays 0. A subsequent 4+ clock stable high -> RUN.
4. In RUN, 2 clocks after a tick press run (STOP), wait 20 clocks, press run again -> no cnt_en while stopped. The first tick after resuming comes 3 clocks after re-entering RUN.
5. In RUN press btn_clear -> ignored, ticks continue. Press run (STOP), then press clear -> state 0->2->0, cnt_clr high for exactly 1 cycle, prescaler=0.
6. In STOP, raise btn_run and btn_clear on the same edge -> state goes to 2 then 0, never 1. Pull reset low mid-debounce in RUN -> all outputs 0 immediately.
